// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if -- signal bundle between the keypad scanner and the
// outside world (keypad matrix plus MCU).
//   COL       : keypad columns C,A,E on bits [2:0], pulled up, low = pressed
//   ROW       : keypad row drives B,G,F,D on bits [0:3], active-low
//   DATA      : code of the last accepted key
//   INTERRUPT : pulse per accepted key (and per auto-repeat when enabled)
//   KEY_DOWN  : high while an accepted key is held
// Modports: master = scanner side, slave = keypad/MCU side.
interface keypad_scanner_if;
  logic [2:0] COL;
  logic [3:0] ROW;
  logic [3:0] DATA;
  logic       INTERRUPT;
  logic       KEY_DOWN;

  modport master (
    input  COL,
    output ROW,
    output DATA,
    output INTERRUPT,
    output KEY_DOWN
  );

  modport slave (
    output COL,
    input  ROW,
    input  DATA,
    input  INTERRUPT,
    input  KEY_DOWN
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x3 matrix keypad scanner with debounce and MCU interrupt.
// Drives one row low at a time, samples the synchronized columns once every
// SCAN_TICKS cycles, debounces presses and releases over DEBOUNCE_COUNT
// samples, latches the key code on DATA and pulses INTERRUPT for INT_CYCLES.
// Ports:
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   bus   : keypad_scanner_if.master (COL in; ROW, DATA, INTERRUPT, KEY_DOWN out)
// Build option: define KEYPAD_AUTOREPEAT_EN to raise a repeat INTERRUPT every
// REPEAT_SAMPLES consecutive pressed samples while a key is held.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int INT_CYCLES     = 4,
  parameter int REPEAT_SAMPLES = 300
) (
  input  logic             CLK,
  input  logic             RESET,
  keypad_scanner_if.master bus
);

  localparam int TICK_W = $clog2(SCAN_TICKS + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_COUNT + 1);
  localparam int INT_W  = $clog2(INT_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_COUNT);
  localparam logic [INT_W-1:0]  INT_LOAD  = INT_W'(INT_CYCLES);

  // The column path needs at least three cycles to settle after a row change
  // before it is sampled; shorter dwell times would sample a stale row.
  if (SCAN_TICKS < 3 || DEBOUNCE_COUNT < 2 || INT_CYCLES < 1 || REPEAT_SAMPLES < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_TICKS>=3, DEBOUNCE_COUNT>=2, INT_CYCLES>=1, REPEAT_SAMPLES>=1 required");
  end

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Active-low one-hot row to row number.
  function automatic logic [1:0] row_index(input logic [3:0] row);
    case (row)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      4'b0111: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  // Returns {valid, code}; valid only when exactly one column is low.
  function automatic logic [4:0] decode_key(input logic [1:0] ri, input logic [2:0] col);
    logic [1:0] ci;
    logic       valid;
    logic [3:0] code;
    valid = 1'b1;
    ci    = 2'd0;
    case (col)
      3'b011:  ci = 2'd0;
      3'b101:  ci = 2'd1;
      3'b110:  ci = 2'd2;
      default: valid = 1'b0;
    endcase
    if (ri == 2'd3) begin
      case (ci)
        2'd0:    code = 4'hA;
        2'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = ({2'b00, ri} * 4'd3) + {2'b00, ci} + 4'd1;
    end
    decode_key = {valid, code};
  endfunction

  state_t              state_r, state_nx_s;
  logic [2:0]          col_meta_r, col_sync_r;
  logic [TICK_W-1:0]   tick_r;
  logic [3:0]          row_r, row_nx_s;
  logic [3:0]          cand_r, cand_nx_s;
  logic [DEB_W-1:0]    cnt_r, cnt_nx_s;
  logic [3:0]          data_r, data_nx_s;
  logic                key_down_r, key_down_nx_s;
  logic [INT_W-1:0]    int_cnt_r;
  logic                interrupt_r;
  logic                sample_s, fire_s, key_valid_s;
  logic [3:0]          key_code_s;
  logic [3:0]          row_rot_s;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SAMPLES);
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_nx_s;
`endif

  assign sample_s  = (tick_r == TICK_LAST);
  assign row_rot_s = {row_r[2:0], row_r[3]};
  assign {key_valid_s, key_code_s} = decode_key(row_index(row_r), col_sync_r);

  assign bus.ROW       = row_r;
  assign bus.DATA      = data_r;
  assign bus.INTERRUPT = interrupt_r;
  assign bus.KEY_DOWN  = key_down_r;

  // Column synchronizer and sample-interval tick counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col_meta_r <= 3'b000;
      col_sync_r <= 3'b000;
      tick_r     <= {TICK_W{1'b0}};
    end else begin
      col_meta_r <= bus.COL;
      col_sync_r <= col_meta_r;
      tick_r     <= sample_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
    end
  end

  // FSM state and its datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_SCAN;
      row_r      <= 4'b1110;
      cand_r     <= 4'h0;
      cnt_r      <= {DEB_W{1'b0}};
      data_r     <= 4'h0;
      key_down_r <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r  <= {REP_W{1'b0}};
`endif
    end else begin
      state_r    <= state_nx_s;
      row_r      <= row_nx_s;
      cand_r     <= cand_nx_s;
      cnt_r      <= cnt_nx_s;
      data_r     <= data_nx_s;
      key_down_r <= key_down_nx_s;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r  <= rep_cnt_nx_s;
`endif
    end
  end

  // Next-state logic; decisions are only taken on sample cycles.
  always_comb begin
    state_nx_s    = state_r;
    row_nx_s      = row_r;
    cand_nx_s     = cand_r;
    cnt_nx_s      = cnt_r;
    data_nx_s     = data_r;
    key_down_nx_s = key_down_r;
    fire_s        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nx_s  = rep_cnt_r;
`endif
    if (sample_s) begin
      case (state_r)
        ST_SCAN: begin
          if (key_valid_s) begin
            cand_nx_s  = key_code_s;
            cnt_nx_s   = DEB_W'(1);
            state_nx_s = ST_CONFIRM;
          end else begin
            row_nx_s = row_rot_s;
          end
        end
        ST_CONFIRM: begin
          if (key_valid_s && (key_code_s == cand_r)) begin
            if ((cnt_r + DEB_W'(1)) == DEB_LAST) begin
              data_nx_s     = cand_r;
              key_down_nx_s = 1'b1;
              fire_s        = 1'b1;
              state_nx_s    = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_nx_s  = {REP_W{1'b0}};
`endif
            end else begin
              cnt_nx_s = cnt_r + DEB_W'(1);
            end
          end else begin
            state_nx_s = ST_SCAN;
            row_nx_s   = row_rot_s;
          end
        end
        ST_HELD: begin
          // A different key on the held row keeps us here but is never accepted.
          if (!key_valid_s) begin
            cnt_nx_s     = DEB_W'(1);
            state_nx_s   = ST_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_nx_s = {REP_W{1'b0}};
`endif
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (key_code_s != data_r) begin
              rep_cnt_nx_s = {REP_W{1'b0}};
            end else if ((rep_cnt_r + REP_W'(1)) == REP_LAST) begin
              rep_cnt_nx_s = {REP_W{1'b0}};
              fire_s       = 1'b1;
            end else begin
              rep_cnt_nx_s = rep_cnt_r + REP_W'(1);
            end
`else
            state_nx_s = ST_HELD;
`endif
          end
        end
        ST_RELEASE: begin
          if (!key_valid_s) begin
            if ((cnt_r + DEB_W'(1)) == DEB_LAST) begin
              key_down_nx_s = 1'b0;
              state_nx_s    = ST_SCAN;
              row_nx_s      = row_rot_s;
            end else begin
              cnt_nx_s = cnt_r + DEB_W'(1);
            end
          end else if (key_code_s == data_r) begin
            state_nx_s = ST_HELD;
          end else begin
            state_nx_s = ST_RELEASE;
          end
        end
        default: begin
          state_nx_s = ST_SCAN;
          row_nx_s   = 4'b1110;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // INTERRUPT pulse stretcher; a new acceptance reloads the full width.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_cnt_r   <= {INT_W{1'b0}};
      interrupt_r <= 1'b0;
    end else begin
      if (fire_s) begin
        int_cnt_r <= INT_LOAD;
      end else if (int_cnt_r != {INT_W{1'b0}}) begin
        int_cnt_r <= int_cnt_r - INT_W'(1);
      end else begin
        int_cnt_r <= int_cnt_r;
      end
      interrupt_r <= fire_s | (int_cnt_r > INT_W'(1));
    end
  end

endmodule
